// File: rtl/net_sched_pkg.sv
// Shared types and helpers for the NIC transmit scheduler and its rate limiter.
// Round-robin picking is kept here so the RX side can reuse the same fairness rule.
package net_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int RLIMIT_W  = 8;
   localparam int MAX_PORTS = 8;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } rr_pick_t;

   // Scans from the port after lastIdx, wrapping at nPorts; the first requester found wins.
   function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] valid,
                                        input logic [2:0]           lastIdx,
                                        input int                   nPorts);
      rr_pick_t res;
      int       cand;
      res = '0;
      for (int k = 1; k <= MAX_PORTS; k++) begin
         cand = (int'(lastIdx) + k) % nPorts;
         if (k <= nPorts && !res.hit && valid[cand[2:0]]) begin
            res.hit = 1'b1;
            res.idx = cand[2:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/net_rate_limiter.sv
// Token-bucket beat limiter: a period counter produces refill ticks and each accepted beat
// spends one token. The refill logic runs independently of any output stall.
module net_rate_limiter
   import net_sched_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [RLIMIT_W-1:0] rlimit_inc,
   input  logic [RLIMIT_W-1:0] rlimit_period,
   input  logic [RLIMIT_W-1:0] rlimit_size,
   input  logic                fire,
   output logic                beat_ok
);

   localparam int SUM_W = RLIMIT_W + 2;

   logic [RLIMIT_W-1:0] tokens_q;
   logic [RLIMIT_W-1:0] tokens_d;
   logic [RLIMIT_W-1:0] periodCnt_q;
   logic [RLIMIT_W-1:0] periodCnt_d;
   logic                tick;
   logic [SUM_W-1:0]    tokenSum;

   // The >= compare lets a lowered period take effect at once instead of waiting for a wrap.
   always_comb begin
      tick        = (periodCnt_q >= rlimit_period);
      periodCnt_d = tick ? '0 : periodCnt_q + RLIMIT_W'(1);
      tokenSum    = {2'b00, tokens_q} - {{(SUM_W-1){1'b0}}, fire}
                    + (tick ? {2'b00, rlimit_inc} : {SUM_W{1'b0}});
      tokens_d    = (tokenSum > {2'b00, rlimit_size}) ? rlimit_size : tokenSum[RLIMIT_W-1:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tokens_q    <= '0;
         periodCnt_q <= '0;
      end else begin
         tokens_q    <= tokens_d;
         periodCnt_q <= periodCnt_d;
      end
   end

   assign beat_ok = (tokens_q != '0);

endmodule

// File: rtl/net_tx_scheduler.sv
// Packet-granular round-robin mux of N_PORTS requester streams onto one NIC output,
// throttled per beat by a token bucket.
module net_tx_scheduler
   import net_sched_pkg::*;
#(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 64,
   parameter int IDX_W   = $clog2(N_PORTS)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [N_PORTS-1:0]            in_valid,
   output logic [N_PORTS-1:0]            in_ready,
   input  logic [N_PORTS*DATA_W-1:0]     in_data,
   input  logic [N_PORTS*DATA_W/8-1:0]   in_keep,
   input  logic [N_PORTS-1:0]            in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic [DATA_W/8-1:0]           out_keep,
   output logic                          out_last,
   input  logic [RLIMIT_W-1:0]           rlimit_inc,
   input  logic [RLIMIT_W-1:0]           rlimit_period,
   input  logic [RLIMIT_W-1:0]           rlimit_size,
   output logic [IDX_W-1:0]              grant_idx,
   output logic                          busy
);

   localparam int KEEP_W = DATA_W / 8;

   state_t                 state_q;
   logic [IDX_W-1:0]       grantIdx_q;
   logic                   busy_q;
   logic                   beatOk;
   logic                   fire;
   logic [MAX_PORTS-1:0]   validPad;
   rr_pick_t               pick;

   assign validPad = MAX_PORTS'(in_valid);
   assign pick     = rr_pick(validPad, 3'(grantIdx_q), N_PORTS);
   assign fire     = out_valid & out_ready;

   // Grant starts at the last port so that port 0 is the first one looked at after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         grantIdx_q <= IDX_W'(N_PORTS - 1);
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick.hit) begin
                  grantIdx_q <= IDX_W'(pick.idx);
                  state_q    <= BUSY;
                  busy_q     <= 1'b1;
               end
            end
            BUSY: begin
               if (fire && out_last) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Zero-latency passthrough from the locked port; a source dropping valid leaves a bubble.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_keep  = '0;
      out_last  = 1'b0;
      in_ready  = '0;
      if (state_q == BUSY) begin
         out_valid            = in_valid[grantIdx_q] & beatOk;
         out_data             = in_data[int'(grantIdx_q)*DATA_W +: DATA_W];
         out_keep             = in_keep[int'(grantIdx_q)*KEEP_W +: KEEP_W];
         out_last             = in_last[grantIdx_q];
         in_ready[grantIdx_q] = out_ready & beatOk;
      end
   end

   net_rate_limiter u_rate_limiter (
      .clock         (clock),
      .reset         (reset),
      .rlimit_inc    (rlimit_inc),
      .rlimit_period (rlimit_period),
      .rlimit_size   (rlimit_size),
      .fire          (fire),
      .beat_ok       (beatOk)
   );

   assign grant_idx = grantIdx_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_net_tx_scheduler.sv
// Directed bench for net_tx_scheduler: scripted requester sources, a beat log, and
// hand-computed beat cycles, ports and payloads for each scenario.
module tb_net_tx_scheduler;

   localparam int N  = 4;
   localparam int DW = 64;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    inValid = '0;
   logic [N-1:0]    inReady;
   logic [N*DW-1:0] inData = '0;
   logic [N*8-1:0]  inKeep = '0;
   logic [N-1:0]    inLast = '0;
   logic            outValid;
   logic            outReady = 1'b1;
   logic [DW-1:0]   outData;
   logic [7:0]      outKeep;
   logic            outLast;
   logic [7:0]      rlInc = 8'd1;
   logic [7:0]      rlPeriod = 8'd0;
   logic [7:0]      rlSize = 8'd8;
   logic [1:0]      grantIdx;
   logic            busy;

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;

   int srcLen[N];
   int srcPkts[N];
   int srcBeat[N];
   int srcSeq[N];
   bit srcHold[N];

   int          logCyc[$];
   logic [63:0] logData[$];
   logic        logLast[$];
   logic [7:0]  logKeep[$];

   logic          capValid;
   logic [N-1:0]  capReady;
   logic          capBusy;
   logic [1:0]    capGrant;
   logic [63:0]   capData;

   always #5 clock = ~clock;

   net_tx_scheduler #(.N_PORTS(N), .DATA_W(DW)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (inValid),
      .in_ready      (inReady),
      .in_data       (inData),
      .in_keep       (inKeep),
      .in_last       (inLast),
      .out_valid     (outValid),
      .out_ready     (outReady),
      .out_data      (outData),
      .out_keep      (outKeep),
      .out_last      (outLast),
      .rlimit_inc    (rlInc),
      .rlimit_period (rlPeriod),
      .rlimit_size   (rlSize),
      .grant_idx     (grantIdx),
      .busy          (busy)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearSources();
      for (int p = 0; p < N; p++) begin
         srcLen[p]  = 1;
         srcPkts[p] = 0;
         srcBeat[p] = 0;
         srcSeq[p]  = 0;
         srcHold[p] = 1'b0;
      end
      inValid = '0;
   endtask

   task automatic clearLog();
      logCyc.delete();
      logData.delete();
      logLast.delete();
      logKeep.delete();
   endtask

   // One clock: drive sources at the falling edge, sample, then retire handshakes at the rising edge.
   task automatic applyStimulus();
      for (int p = 0; p < N; p++) begin
         inValid[p]         = (srcPkts[p] > 0) && !srcHold[p];
         inData[p*DW +: DW] = {32'(p), 32'(srcSeq[p])};
         inLast[p]          = (srcBeat[p] == srcLen[p] - 1);
         inKeep[p*8 +: 8]   = inLast[p] ? 8'h0F : 8'hFF;
      end
      #1;
      capValid = outValid;
      capReady = inReady;
      capBusy  = busy;
      capGrant = grantIdx;
      capData  = outData;
      if (outValid && outReady) begin
         logCyc.push_back(cyc);
         logData.push_back(outData);
         logLast.push_back(outLast);
         logKeep.push_back(outKeep);
      end
      @(posedge clock);
      for (int p = 0; p < N; p++) begin
         if (inValid[p] && capReady[p]) begin
            srcSeq[p]++;
            srcBeat[p]++;
            if (srcBeat[p] == srcLen[p]) begin
               srcBeat[p] = 0;
               srcPkts[p]--;
            end
         end
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic runSteps(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic doReset(input logic [7:0] inc, input logic [7:0] per, input logic [7:0] size);
      @(negedge clock);
      reset    = 1'b0;
      outReady = 1'b1;
      rlInc    = inc;
      rlPeriod = per;
      rlSize   = size;
      clearSources();
      #1;
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_in_ready", 64'(inReady), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_grant", 64'(grantIdx), 64'd3);
      @(negedge clock);
      reset = 1'b1;
      cyc   = 0;
      clearLog();
   endtask

   task automatic checkBeat(input string tag, input int i, input int expCyc, input int expPort,
                            input int expSeq, input bit expLast);
      string t;
      t = $sformatf("%s_b%0d", tag, i);
      if (i >= logCyc.size()) begin
         checkOutput({t, "_present"}, 64'(logCyc.size()), 64'(i + 1));
      end else begin
         checkOutput({t, "_cyc"}, 64'(logCyc[i]), 64'(expCyc));
         checkOutput({t, "_data"}, logData[i], {32'(expPort), 32'(expSeq)});
         checkOutput({t, "_last"}, 64'(logLast[i]), 64'(expLast));
         checkOutput({t, "_keep"}, 64'(logKeep[i]), expLast ? 64'h0F : 64'hFF);
      end
   endtask

   initial begin
      int expPorts[12];
      int expCycs[12];
      int expSeq[N];

      // Single 4-beat packet from port 2: grant lands at posedge 0, beats on cycles 1..4.
      doReset(8'd1, 8'd0, 8'd8);
      srcLen[2] = 4; srcPkts[2] = 1; srcSeq[2] = 32'hA0;
      applyStimulus();
      checkOutput("t1_grant_before", 64'(capGrant), 64'd3);
      checkOutput("t1_busy_before", 64'(capBusy), 64'd0);
      applyStimulus();
      checkOutput("t1_grant", 64'(capGrant), 64'd2);
      checkOutput("t1_busy", 64'(capBusy), 64'd1);
      runSteps(8);
      checkOutput("t1_count", 64'(logCyc.size()), 64'd4);
      for (int i = 0; i < 4; i++) checkBeat("t1", i, 1 + i, 2, 32'hA0 + i, i == 3);
      checkOutput("t1_busy_after", 64'(capBusy), 64'd0);
      checkOutput("t1_grant_after", 64'(capGrant), 64'd2);

      // Round robin over ports 0,1,3 with two 2-beat packets each and a bubble between packets.
      doReset(8'd1, 8'd0, 8'd8);
      srcLen[0] = 2; srcPkts[0] = 2;
      srcLen[1] = 2; srcPkts[1] = 2;
      srcLen[3] = 2; srcPkts[3] = 2;
      expPorts = '{0, 0, 1, 1, 3, 3, 0, 0, 1, 1, 3, 3};
      expCycs  = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14, 16, 17};
      runSteps(20);
      checkOutput("t2_count", 64'(logCyc.size()), 64'd12);
      for (int p = 0; p < N; p++) expSeq[p] = 0;
      for (int i = 0; i < 12; i++) begin
         checkBeat("t2", i, expCycs[i], expPorts[i], expSeq[expPorts[i]], (i % 2) == 1);
         expSeq[expPorts[i]]++;
      end

      // Rate limit inc=1 period=3 size=1: one beat every 4 cycles starting at cycle 4.
      doReset(8'd1, 8'd3, 8'd1);
      srcLen[0] = 16; srcPkts[0] = 1;
      runSteps(3);
      checkOutput("t3_starved_valid", 64'(capValid), 64'd0);
      checkOutput("t3_starved_ready", 64'(capReady), 64'd0);
      runSteps(67);
      checkOutput("t3_count", 64'(logCyc.size()), 64'd16);
      for (int i = 0; i < 16; i++) checkBeat("t3", i, 4 * (i + 1), 0, i, i == 15);

      // Burst: bucket fills to 8 during 10 idle cycles, then 12 beats go back to back.
      doReset(8'd2, 8'd0, 8'd8);
      runSteps(10);
      srcLen[1] = 12; srcPkts[1] = 1;
      runSteps(15);
      checkOutput("t4_count", 64'(logCyc.size()), 64'd12);
      for (int i = 0; i < 12; i++) checkBeat("t4", i, 11 + i, 1, i, i == 11);

      // Backpressure on alternate cycles, then size=0 disables the output entirely.
      doReset(8'd1, 8'd0, 8'd8);
      srcLen[2] = 4; srcPkts[2] = 1;
      for (int s = 0; s < 9; s++) begin
         outReady = (s % 2) == 1;
         applyStimulus();
         if (s == 2) begin
            checkOutput("t5_stall_valid", 64'(capValid), 64'd1);
            checkOutput("t5_stall_data", capData, {32'd2, 32'd1});
            checkOutput("t5_stall_ready", 64'(capReady), 64'd0);
         end
      end
      checkOutput("t5_count", 64'(logCyc.size()), 64'd4);
      for (int i = 0; i < 4; i++) checkBeat("t5", i, 1 + 2 * i, 2, i, i == 3);
      rlSize = 8'd0; outReady = 1'b1; srcPkts[2] = 1;
      runSteps(21);
      checkOutput("t5_disabled_count", 64'(logCyc.size()), 64'd4);
      checkOutput("t5_disabled_busy", 64'(capBusy), 64'd1);
      checkOutput("t5_disabled_valid", 64'(capValid), 64'd0);
      checkOutput("t5_disabled_ready", 64'(capReady), 64'd0);

      // Requester drops valid mid-packet: lock is kept, port 1 waits for the last beat.
      doReset(8'd1, 8'd0, 8'd8);
      srcLen[0] = 4; srcPkts[0] = 1;
      srcLen[1] = 1; srcPkts[1] = 1;
      runSteps(2);
      srcHold[0] = 1'b1;
      applyStimulus();
      checkOutput("t7_gap_busy", 64'(capBusy), 64'd1);
      checkOutput("t7_gap_valid", 64'(capValid), 64'd0);
      checkOutput("t7_gap_ready", 64'(capReady), 64'b0001);
      checkOutput("t7_gap_grant", 64'(capGrant), 64'd0);
      applyStimulus();
      srcHold[0] = 1'b0;
      runSteps(6);
      checkOutput("t7_count", 64'(logCyc.size()), 64'd5);
      checkBeat("t7", 0, 1, 0, 0, 1'b0);
      checkBeat("t7", 1, 4, 0, 1, 1'b0);
      checkBeat("t7", 2, 5, 0, 2, 1'b0);
      checkBeat("t7", 3, 6, 0, 3, 1'b1);
      checkBeat("t7", 4, 8, 1, 0, 1'b1);

      // Asynchronous reset during beat 3 of 5; afterwards port 0 wins and tokens restart at 0.
      doReset(8'd1, 8'd0, 8'd8);
      srcLen[1] = 5; srcPkts[1] = 1;
      runSteps(3);
      checkOutput("t6_pre_count", 64'(logCyc.size()), 64'd2);
      applyStimulus();
      checkOutput("t6_pre_valid", 64'(capValid), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("t6_abort_valid", 64'(outValid), 64'd0);
      checkOutput("t6_abort_ready", 64'(inReady), 64'd0);
      checkOutput("t6_abort_busy", 64'(busy), 64'd0);
      checkOutput("t6_abort_grant", 64'(grantIdx), 64'd3);
      @(negedge clock);
      rlInc = 8'd1; rlPeriod = 8'd3; rlSize = 8'd4;
      clearSources();
      srcLen[0] = 1; srcPkts[0] = 1; srcSeq[0] = 32'h100;
      srcLen[1] = 1; srcPkts[1] = 1; srcSeq[1] = 32'h100;
      @(negedge clock);
      reset = 1'b1;
      cyc   = 0;
      clearLog();
      runSteps(12);
      checkOutput("t6_count", 64'(logCyc.size()), 64'd2);
      checkBeat("t6", 0, 4, 0, 32'h100, 1'b1);
      checkBeat("t6", 1, 8, 1, 32'h100, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
